axi_ram_rd_arbiter: RTL

//  Round-robin arbiter sharing the AXI4 read channel (AR+R) of one axi_ram between S_COUNT read masters.

---
 rtl/axi_ram_rd_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axi_ram_rd_arbiter.sv
// Round-robin arbiter sharing one axi_ram AR/R read channel among S_COUNT masters.
// One burst in flight at a time; R beats are steered to the granted master only.
module axi_ram_rd_arbiter #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [S_COUNT*ID_WIDTH-1:0]    s_axi_arid,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [S_COUNT*8-1:0]           s_axi_arlen,
    input  logic [S_COUNT*3-1:0]           s_axi_arsize,
    input  logic [S_COUNT*2-1:0]           s_axi_arburst,
    input  logic [S_COUNT-1:0]             s_axi_arvalid,
    output logic [S_COUNT-1:0]             s_axi_arready,
    output logic [S_COUNT*ID_WIDTH-1:0]    s_axi_rid,
    output logic [S_COUNT*DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [S_COUNT*2-1:0]           s_axi_rresp,
    output logic [S_COUNT-1:0]             s_axi_rlast,
    output logic [S_COUNT-1:0]             s_axi_rvalid,
    input  logic [S_COUNT-1:0]             s_axi_rready,
    output logic [ID_WIDTH-1:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [ID_WIDTH-1:0]            m_axi_rid,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    output logic                           rlast_err
);
    localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                r_state;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last_grant;
    logic [7:0]            r_beat_cnt;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic                  r_arvalid;
    logic                  r_rlast_err;

    logic [GW-1:0]         w_sel;
    logic [GW-1:0]         w_idx;
    logic                  w_any;
    logic [ID_WIDTH-1:0]   w_arid;
    logic [ADDR_WIDTH-1:0] w_araddr;
    logic [7:0]            w_arlen;
    logic [2:0]            w_arsize;
    logic [1:0]            w_arburst;
    logic                  w_r_hs;
    logic                  w_last_beat;

    // Search from last_grant+1 upward; iterating downward lets the nearest requester win.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_last_grant;
        w_idx = '0;
        for (int i = S_COUNT; i >= 1; i--) begin
            w_idx = GW'((int'(r_last_grant) + i) % S_COUNT);
            if (s_axi_arvalid[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_arid    = '0;
        w_araddr  = '0;
        w_arlen   = '0;
        w_arsize  = '0;
        w_arburst = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (w_sel == GW'(k)) begin
                w_arid    = s_axi_arid[k*ID_WIDTH +: ID_WIDTH];
                w_araddr  = s_axi_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_arlen   = s_axi_arlen[k*8 +: 8];
                w_arsize  = s_axi_arsize[k*3 +: 3];
                w_arburst = s_axi_arburst[k*2 +: 2];
            end
        end
    end

    // arready is gated by rst so no handshake can be accepted while reset is held.
    always_comb begin
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            s_axi_arready[k] = !rst && (r_state == IDLE) && w_any && (w_sel == GW'(k));
            s_axi_rvalid[k]  = (r_state == DATA) && (r_grant == GW'(k)) && m_axi_rvalid;
        end
    end

    assign m_axi_rready = (r_state == DATA) && s_axi_rready[r_grant];
    assign w_r_hs       = (r_state == DATA) && m_axi_rvalid && m_axi_rready;
    assign w_last_beat  = (r_beat_cnt == r_arlen);

    assign s_axi_rid   = {S_COUNT{m_axi_rid}};
    assign s_axi_rdata = {S_COUNT{m_axi_rdata}};
    assign s_axi_rresp = {S_COUNT{m_axi_rresp}};
    assign s_axi_rlast = {S_COUNT{m_axi_rlast}};

    assign m_axi_arid    = r_arid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = r_arsize;
    assign m_axi_arburst = r_arburst;
    assign m_axi_arvalid = r_arvalid;
    assign rlast_err     = r_rlast_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(S_COUNT - 1);
            r_beat_cnt   <= '0;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
            r_arvalid    <= 1'b0;
            r_rlast_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_sel;
                        r_arid     <= w_arid;
                        r_araddr   <= w_araddr;
                        r_arlen    <= w_arlen;
                        r_arsize   <= w_arsize;
                        r_arburst  <= w_arburst;
                        r_beat_cnt <= '0;
                        r_arvalid  <= 1'b1;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    // The burst ends on the beat count; RAM rlast is only cross-checked.
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (m_axi_rlast != w_last_beat)
                            r_rlast_err <= 1'b1;
                        if (w_last_beat) begin
                            r_last_grant <= r_grant;
                            r_state      <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
